pwm_audio_out: RTL and testbench

//  Final audio stage, downstream of the square-wave generator / shifter chain.
//  - Accepts 8-bit shifted samples through a valid/ready handshake into a small FIFO.
//  - Converts each sample to a pulse-width-modulated 1-bit output that drives the speaker/RC filter.
//  - Reports FIFO underrun to the control logic.

---
 rtl/sound_pkg.sv | 16 +
 rtl/sample_fifo.sv | 63 ++++++
 rtl/pwm_audio_out.sv | 92 +++++++++
 tb/tb_pwm_audio_out.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared audio-path types and LFSR constants for the PWM output stage.
package sound_pkg;

    localparam int unsigned SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam sample_t LFSR_TAPS = 8'hB8;
    localparam sample_t LFSR_SEED = 8'hA5;

    function automatic sample_t lfsr_next(input sample_t s);
        return {s[SAMPLE_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Circular-buffer sample FIFO; pushes are dropped when full, pops when empty.
module sample_fifo
    import sound_pkg::*;
#(
    parameter int unsigned W     = SAMPLE_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wr_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full_c    = (level_q == LW'(DEPTH));
    assign empty_c   = (level_q == '0);
    assign do_push   = push && !full_c;
    assign do_pop    = pop && !empty_c;
    assign rd_data_c = mem[rd_ptr];
    assign level     = level_q;

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: buffers samples and emits one duty-cycle period per sample.
// Optional dither on the popped sample is enabled by defining PWM_AUDIO_DITHER_EN.
module pwm_audio_out
    import sound_pkg::*;
#(
    parameter int unsigned WIDTH      = SAMPLE_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            sample_in,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic                        pwm_out,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  presc_q;
    logic [WIDTH-1:0] pwm_q;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_pop;
    logic [WIDTH-1:0] head;
    logic             tick;
    logic             boundary;
    logic             fifo_full;
    logic             fifo_empty;

    assign tick         = (presc_q == PS_W'(PRESCALE - 1));
    assign boundary     = tick && (pwm_q == '1);
    assign underrun     = boundary && fifo_empty;
    assign sample_ready = !fifo_full;

    sample_fifo #(
        .W     (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sample_valid),
        .wr_data   (sample_in),
        .pop       (boundary),
        .rd_data_c (head),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty),
        .level     (fifo_level)
    );

`ifdef PWM_AUDIO_DITHER_EN
    localparam int unsigned SUM_W = WIDTH + 1;

    sample_t          lfsr_q;
    logic [SUM_W-1:0] dith_sum;

    // LFSR steps once per period, whether or not a sample was available
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (boundary) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign dith_sum = {1'b0, head} + SUM_W'(lfsr_q[0]);
    assign duty_pop = dith_sum[WIDTH] ? '1 : dith_sum[WIDTH-1:0];
`else
    assign duty_pop = head;
`endif

    // Prescaler, period counter, duty latch and registered compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pwm_q   <= '0;
            duty_q  <= '0;
            pwm_out <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PS_W'(1);
            if (tick) begin
                pwm_q <= pwm_q + WIDTH'(1);
            end
            if (boundary && !fifo_empty) begin
                duty_q <= duty_pop;
            end
            pwm_out <= (pwm_q < duty_q);
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out against a period-level behavioural model.
module tb_pwm_audio_out;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PRESCALE   = 1;
    localparam int          PERIOD     = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_level;

    pwm_audio_out #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PRESCALE   (PRESCALE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: elapsed cycles since reset, queued samples, current duty, next pwm bit
    int         mq[$];
    int         m_duty;
    int         m_t;
    bit         m_pwm;
    logic [7:0] m_lfsr;

    logic  obs_pwm, obs_und, obs_rdy;
    int    obs_lvl;
    int    c_t;
    int    cyc_bad;
    string first_bad;
    int    hi_cnt;
    int    und_log[$];

    task automatic model_reset();
        mq.delete();
        m_duty = 0;
        m_t    = 0;
        m_pwm  = 1'b0;
        m_lfsr = 8'hA5;
    endtask

    // One clock cycle: drive, sample against the model, then advance the model across the edge
    task automatic cycle(input bit v, input logic [7:0] d);
        bit e_pwm, e_und, e_rdy, bnd, acc;
        int e_lvl, h;
        sample_valid = v;
        sample_in    = d;
        #1;
        obs_pwm = pwm_out;
        obs_und = underrun;
        obs_rdy = sample_ready;
        obs_lvl = int'(fifo_level);
        c_t     = m_t;
        bnd   = (m_t % PERIOD) == PERIOD - 1;
        e_pwm = m_pwm;
        e_und = bnd && (mq.size() == 0);
        e_lvl = mq.size();
        e_rdy = (mq.size() != int'(FIFO_DEPTH));
        if (obs_pwm !== e_pwm || obs_und !== e_und || obs_lvl !== e_lvl || obs_rdy !== e_rdy) begin
            cyc_bad++;
            if (cyc_bad == 1)
                first_bad = $sformatf("t=%0d pwm=%b/%b und=%b/%b lvl=%0d/%0d rdy=%b/%b",
                                      c_t, obs_pwm, e_pwm, obs_und, e_und, obs_lvl, e_lvl, obs_rdy, e_rdy);
        end
        if (obs_pwm === 1'b1) hi_cnt++;
        if (obs_und === 1'b1) und_log.push_back(c_t);
        acc = v && e_rdy;
        @(posedge clk);
        m_pwm = (m_t % PERIOD) < m_duty;
        if (bnd) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
`ifdef PWM_AUDIO_DITHER_EN
                m_duty = (h + int'(m_lfsr[0]) > 255) ? 255 : h + int'(m_lfsr[0]);
`else
                m_duty = h;
`endif
            end
`ifdef PWM_AUDIO_DITHER_EN
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        end
        if (acc) mq.push_back(int'(d));
        m_t++;
        #1;
    endtask

    task automatic to_boundary();
        do cycle(1'b0, 8'h00); while ((m_t % PERIOD) != 0);
    endtask

    task automatic period_highs(output int h, output int d);
        d      = m_duty;
        hi_cnt = 0;
        repeat (PERIOD) cycle(1'b0, 8'h00);
        h = hi_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if (pwm_out !== 1'b0 || underrun !== 1'b0 || sample_ready !== 1'b1 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_pre_edge: pwm=%b und=%b rdy=%b lvl=%0d, want 0 0 1 0",
                     pwm_out, underrun, sample_ready, fifo_level);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (pwm_out !== 1'b0 || underrun !== 1'b0 || sample_ready !== 1'b1 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_held: pwm=%b und=%b rdy=%b lvl=%0d, want 0 0 1 0",
                     pwm_out, underrun, sample_ready, fifo_level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        cyc_bad = 0; hi_cnt = 0; und_log.delete();
        repeat (600) cycle(1'b0, 8'h00);
        n_cmp++;
        if (und_log.size() != 2 || und_log[0] != 255 || und_log[1] != 511) begin
            n_fail++;
            $display("FAIL idle_underrun: got %0d pulses first=%0d, want pulses at 255 and 511",
                     und_log.size(), (und_log.size() > 0) ? und_log[0] : -1);
        end
        n_cmp++;
        if (hi_cnt !== 0) begin
            n_fail++;
            $display("FAIL idle_pwm: got %0d high cycles, want 0", hi_cnt);
        end
        n_cmp++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL idle_cycle: %0d bad cycles, first %s", cyc_bad, first_bad);
        end
    endtask

    task automatic test_single();
        int h, d;
        cyc_bad = 0;
        cycle(1'b1, 8'd64);
        to_boundary();
        period_highs(h, d);
        n_cmp++;
        if (h !== d || d < 64 || d > 65) begin
            n_fail++;
            $display("FAIL single_64_highs: got %0d, want %0d", h, d);
        end
        n_cmp++;
        if (obs_lvl !== 0) begin
            n_fail++;
            $display("FAIL single_level: got %0d, want 0", obs_lvl);
        end
        period_highs(h, d);
        n_cmp++;
        if (h !== d) begin
            n_fail++;
            $display("FAIL single_hold_highs: got %0d, want %0d", h, d);
        end
        n_cmp++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL single_cycle: %0d bad cycles, first %s", cyc_bad, first_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [5];
        int idx, guard, s, acc_t, h, d;
        cyc_bad = 0;
        foreach (data[i]) data[i] = 8'($urandom);
        to_boundary();
        s = m_t; idx = 0; guard = 0; acc_t = -1;
        while (idx < 5 && guard < 400) begin
            cycle(1'b1, data[idx]);
            if (c_t == s + 4) begin
                n_cmp++;
                if (obs_lvl !== 4 || obs_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_full: lvl=%0d rdy=%b, want 4 0", obs_lvl, obs_rdy);
                end
            end
            if (c_t == s + PERIOD) begin
                n_cmp++;
                if (obs_lvl !== 3 || obs_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_after_pop: lvl=%0d rdy=%b, want 3 1", obs_lvl, obs_rdy);
                end
            end
            if (obs_rdy === 1'b1) begin
                if (idx == 4) acc_t = c_t;
                idx++;
            end
            guard++;
        end
        cycle(1'b0, 8'h00);
        n_cmp++;
        if (obs_lvl !== 4) begin
            n_fail++;
            $display("FAIL b2b_refill: lvl=%0d, want 4", obs_lvl);
        end
        n_cmp++;
        if (acc_t !== s + PERIOD) begin
            n_fail++;
            $display("FAIL b2b_fifth_accept: cycle %0d, want %0d", acc_t, s + PERIOD);
        end
        to_boundary();
        for (int k = 1; k < 5; k++) begin
            period_highs(h, d);
            n_cmp++;
            if (h !== d || d < int'(data[k]) || d > int'(data[k]) + 1) begin
                n_fail++;
                $display("FAIL b2b_highs[%0d]: got %0d model %0d sample %0d", k, h, d, data[k]);
            end
        end
        n_cmp++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_cycle: %0d bad cycles, first %s", cyc_bad, first_bad);
        end
    endtask

    task automatic test_extremes();
        int h, d;
        cyc_bad = 0;
        cycle(1'b1, 8'd255);
        cycle(1'b1, 8'd0);
        to_boundary();
        period_highs(h, d);
        n_cmp++;
        if (h !== 255) begin
            n_fail++;
            $display("FAIL extreme_255: got %0d highs, want 255", h);
        end
        period_highs(h, d);
        n_cmp++;
        if (h !== d || d > 1) begin
            n_fail++;
            $display("FAIL extreme_0: got %0d highs, want %0d", h, d);
        end
        n_cmp++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL extreme_cycle: %0d bad cycles, first %s", cyc_bad, first_bad);
        end
    endtask

    task automatic test_reset_mid();
        cyc_bad = 0;
        repeat (4) cycle(1'b1, 8'd200);
        to_boundary();
        repeat (50) cycle(1'b0, 8'h00);
        n_cmp++;
        if (obs_pwm !== 1'b1 || obs_lvl !== 3) begin
            n_fail++;
            $display("FAIL midrst_pre: pwm=%b lvl=%0d, want 1 3", obs_pwm, obs_lvl);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pwm_out !== 1'b0 || fifo_level !== 3'd0 || underrun !== 1'b0 || sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_async: pwm=%b lvl=%0d und=%b rdy=%b, want 0 0 0 1",
                     pwm_out, fifo_level, underrun, sample_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        und_log.delete();
        repeat (300) cycle(1'b0, 8'h00);
        n_cmp++;
        if (und_log.size() < 1 || und_log[0] != 255) begin
            n_fail++;
            $display("FAIL midrst_underrun: %0d pulses first=%0d, want first at 255",
                     und_log.size(), (und_log.size() > 0) ? und_log[0] : -1);
        end
        n_cmp++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL midrst_cycle: %0d bad cycles, first %s", cyc_bad, first_bad);
        end
    endtask

    task automatic test_random();
        int h, d;
        logic [7:0] r;
        cyc_bad = 0;
        repeat (1200) begin
            r = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            cycle($urandom_range(0, 3) == 0, r);
        end
        repeat (5) to_boundary();
        repeat (4) cycle(1'b1, 8'd100);
        to_boundary();
        for (int k = 0; k < 4; k++) begin
            period_highs(h, d);
            n_cmp++;
            if (h !== d || d < 100 || d > 101) begin
                n_fail++;
                $display("FAIL random_100_highs[%0d]: got %0d, want %0d", k, h, d);
            end
        end
        n_cmp++;
        if (cyc_bad !== 0) begin
            n_fail++;
            $display("FAIL random_cycle: %0d bad cycles, first %s", cyc_bad, first_bad);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
